cfg_write_arbiter: RTL and testbench

- Arbitrates register-write requests from two masters onto the peripheral's shared configuration register bank: port 0 is the SPI frame decoder, port 1 is a local sequencer or debug master.
- Validates each address and writes the data byte into a shadow bank.
- Copies the shadow bank into the active bank atomically on a commit strobe, e.g. a PWM period boundary, so downstream logic never sees a half-updated configuration.

---
 rtl/cfg_write_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cfg_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cfg_write_arbiter
// Description : Two-port round-robin write arbiter for a config register bank.
//               Optional shadow bank with atomic commit (macro CFG_SHADOW_EN).
// Revision    : 1.0
// ============================================================================
module cfg_write_arbiter #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_vld,
    input  logic [ADDR_W-1:0]          req0_addr,
    input  logic [DATA_W-1:0]          req0_data,
    output logic                       ack0,
    output logic                       err0,
    input  logic                       req1_vld,
    input  logic [ADDR_W-1:0]          req1_addr,
    input  logic [DATA_W-1:0]          req1_data,
    output logic                       ack1,
    output logic                       err1,
    input  logic                       commit,
    output logic [NUM_REGS*DATA_W-1:0] cfg_q,
    output logic                       dirty,
    output logic                       busy
);

    localparam logic [ADDR_W-1:0] c_REG_LIMIT = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic                write_en;
    logic                pick;
    logic                sel_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        write_en = 1'b0;
        pick     = 1'b0;
        sel_vld  = sel_q ? req1_vld : req0_vld;

        case (state_q)
            S_IDLE: begin
                if (req0_vld || req1_vld) begin
                    // On a tie the port that did not win the last write goes first.
                    if (req0_vld && req1_vld) begin
                        pick = ~last_q;
                    end else begin
                        pick = req1_vld;
                    end
                    sel_d   = pick;
                    addr_d  = pick ? req1_addr : req0_addr;
                    data_d  = pick ? req1_data : req0_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (addr_q < c_REG_LIMIT) begin
                    state_d = S_WRITE;
                end else begin
                    err0_d  = ~sel_q;
                    err1_d  = sel_q;
                    state_d = S_HOLD;
                end
            end
            S_WRITE: begin
                write_en = 1'b1;
                ack0_d   = ~sel_q;
                ack1_d   = sel_q;
                last_d   = sel_q;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                // Wait for the granted master to release so a held request is not replayed.
                if (!sel_vld) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef CFG_SHADOW_EN
    logic [NUM_REGS*DATA_W-1:0] shadow_q;
    logic                       dirty_q;

    // Commit copies the pre-write shadow, so a same-edge write stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            cfg_q    <= '0;
            dirty_q  <= 1'b0;
        end else begin
            if (commit && dirty_q) begin
                cfg_q <= shadow_q;
            end
            if (write_en) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr_q == ADDR_W'(k)) begin
                        shadow_q[k*DATA_W +: DATA_W] <= data_q;
                    end
                end
                dirty_q <= 1'b1;
            end else if (commit && dirty_q) begin
                dirty_q <= 1'b0;
            end
        end
    end

    assign dirty = dirty_q;
`else
    logic unused_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= '0;
        end else if (write_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == ADDR_W'(k)) begin
                    cfg_q[k*DATA_W +: DATA_W] <= data_q;
                end
            end
        end
    end

    assign unused_commit = commit;
    assign dirty         = 1'b0;
`endif

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign err0 = err0_q;
    assign err1 = err1_q;
    assign busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cfg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_write_arbiter
// Description : Directed self-checking bench for cfg_write_arbiter
//               (expectations follow CFG_SHADOW_EN when defined).
// Revision    : 1.0
// ============================================================================
module tb_cfg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [6:0]  req0_addr, req1_addr;
    logic [7:0]  req0_data, req1_data;
    logic        ack0, ack1, err0, err1;
    logic        commit;
    logic [39:0] cfg_q;
    logic        dirty, busy;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    cfg_write_arbiter #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_vld  (req0_vld),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .ack0      (ack0),
        .err0      (err0),
        .req1_vld  (req1_vld),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .ack1      (ack1),
        .err1      (err1),
        .commit    (commit),
        .cfg_q     (cfg_q),
        .dirty     (dirty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Out-of-range request: err pulse two edges after drive, nothing written.
    task automatic err_txn(input bit port, input logic [6:0] a, input logic [7:0] d,
                           input logic [39:0] cfg_exp, input string tag);
        if (port) begin
            req1_vld = 1'b1; req1_addr = a; req1_data = d;
        end else begin
            req0_vld = 1'b1; req0_addr = a; req0_data = d;
        end
        tick();
        tick();
        chk({tag, "_err"}, {ack0, err0, ack1, err1}, port ? 4'b0001 : 4'b0100);
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        tick();
        chk({tag, "_after"}, {ack0, err0, ack1, err1, busy}, 5'b0);
        chk({tag, "_cfg"}, cfg_q, cfg_exp);
        chk({tag, "_dirty"}, dirty, 1'b0);
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; commit = 1'b0;
        req0_vld = 1'b0; req0_addr = '0; req0_data = '0;
        req1_vld = 1'b0; req1_addr = '0; req1_data = '0;
        tick();
        tick();
        chk("reset_outs", {ack0, err0, ack1, err1, dirty, busy}, 6'b0);
        chk("reset_cfg", cfg_q, 40'h0);
        rst = 1'b0;
        tick();

        // Tie from reset: port 0 first, then port 1.
        req0_vld = 1'b1; req0_addr = 7'd0; req0_data = 8'h11;
        req1_vld = 1'b1; req1_addr = 7'd1; req1_data = 8'h22;
        tick();
        chk("tie1_busy", busy, 1'b1);
        tick();
        chk("tie1_noack_yet", {ack0, ack1}, 2'b00);
        tick();
        chk("tie1_first", {ack0, err0, ack1, err1}, 4'b1000);
`ifdef CFG_SHADOW_EN
        chk("tie1_shadow_hidden", cfg_q[7:0], 8'h00);
        chk("tie1_dirty", dirty, 1'b1);
`else
        chk("tie1_direct", cfg_q[7:0], 8'h11);
`endif
        req0_vld = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("tie1_second", {ack0, err0, ack1, err1}, 4'b0010);
        req1_vld = 1'b0;
        commit_pulse();
        chk("tie1_commit_cfg", cfg_q, 40'h00_00_00_22_11);
        chk("tie1_commit_dirty", dirty, 1'b0);

        // Single port 0 write, commit later.
        req0_vld = 1'b1; req0_addr = 7'd2; req0_data = 8'hA5;
        tick();
        tick();
        tick();
        chk("p0_ack", {ack0, err0, ack1, err1}, 4'b1000);
`ifdef CFG_SHADOW_EN
        chk("p0_byte2_pre", cfg_q[23:16], 8'h00);
        chk("p0_dirty", dirty, 1'b1);
`else
        chk("p0_byte2_direct", cfg_q[23:16], 8'hA5);
        chk("p0_dirty", dirty, 1'b0);
`endif
        req0_vld = 1'b0;
        tick();
        chk("p0_idle", {ack0, busy}, 2'b00);
        commit_pulse();
        chk("p0_commit_byte2", cfg_q[23:16], 8'hA5);
        chk("p0_commit_dirty", dirty, 1'b0);

        // Port 0 won last, so the next tie goes to port 1.
        req0_vld = 1'b1; req0_addr = 7'd4; req0_data = 8'h44;
        req1_vld = 1'b1; req1_addr = 7'd3; req1_data = 8'h33;
        tick();
        tick();
        tick();
        chk("tie2_first", {ack0, err0, ack1, err1}, 4'b0010);
        req1_vld = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("tie2_second", {ack0, err0, ack1, err1}, 4'b1000);
        req0_vld = 1'b0;
        tick();
        commit_pulse();
        chk("tie2_cfg", cfg_q, 40'h44_33_A5_22_11);

        // Address range boundaries: 7, 5 and 0x42 must not alias a register.
        err_txn(1'b1, 7'd7,  8'h99, 40'h44_33_A5_22_11, "p1_addr7");
        err_txn(1'b0, 7'h42, 8'h77, 40'h44_33_A5_22_11, "p0_addr42");
        err_txn(1'b0, 7'd5,  8'h55, 40'h44_33_A5_22_11, "p0_addr5");

        // Held request: one ack, FSM parked in HOLD.
        req0_vld = 1'b1; req0_addr = 7'd1; req0_data = 8'h5A;
        tick();
        tick();
        tick();
        chk("hold_ack", {ack0, err0, ack1, err1}, 4'b1000);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            acks += int'(ack0);
            tick();
        end
        acks += int'(ack0);
        chk("hold_busy", busy, 1'b1);
        chk("hold_single_ack", 64'(acks - 1), 64'd0);
        req0_vld = 1'b0;
        tick();
        chk("hold_release", busy, 1'b0);
`ifdef CFG_SHADOW_EN
        chk("hold_byte1", cfg_q[15:8], 8'h22);
        chk("hold_dirty", dirty, 1'b1);
`else
        chk("hold_byte1", cfg_q[15:8], 8'h5A);
`endif

        // Commit coincident with the WRITE exit edge.
        req0_vld = 1'b1; req0_addr = 7'd3; req0_data = 8'h3C;
        tick();
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("cw_ack", ack0, 1'b1);
        chk("cw_byte1", cfg_q[15:8], 8'h5A);
`ifdef CFG_SHADOW_EN
        chk("cw_byte3", cfg_q[31:24], 8'h33);
        chk("cw_dirty", dirty, 1'b1);
`else
        chk("cw_byte3", cfg_q[31:24], 8'h3C);
        chk("cw_dirty", dirty, 1'b0);
`endif
        req0_vld = 1'b0;
        tick();
        commit_pulse();
        chk("cw2_byte3", cfg_q[31:24], 8'h3C);
        chk("cw2_dirty", dirty, 1'b0);

        // Asynchronous reset while in CHECK.
        req0_vld = 1'b1; req0_addr = 7'd0; req0_data = 8'hEE;
        tick();
        chk("rst_in_check", busy, 1'b1);
        rst = 1'b1;
        req0_vld = 1'b0;
        #1;
        chk("rst_async_outs", {ack0, err0, ack1, err1, dirty, busy}, 6'b0);
        chk("rst_async_cfg", cfg_q, 40'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_resp", {ack0, err0, ack1, err1, busy}, 5'b0);
        end
        req0_vld = 1'b1; req0_addr = 7'd1; req0_data = 8'h61;
        req1_vld = 1'b1; req1_addr = 7'd2; req1_data = 8'h62;
        tick();
        tick();
        tick();
        chk("rst_tie_p0", {ack0, err0, ack1, err1}, 4'b1000);
`ifndef CFG_SHADOW_EN
        chk("rst_tie_byte1", cfg_q[15:8], 8'h61);
`endif
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
